// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the oversampling UART receiver:
//     rx_state_t     - receiver FSM states
//     OS_MID         - first of the three mid-bit sample indices (7, 8, 9)
//     calc_tick_inc  - fractional-accumulator increment for the 16x tick
//     maj3           - 2-of-3 majority vote over the mid-bit samples
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_t;

    localparam int OS_MID = 7;

    // Rounded ratio (baud*os / clk_freq) scaled to 2^acc_width. The top four
    // bits of the scale are folded into the clk_freq>>4 divisor so that the
    // intermediate product stays inside 64 bits for realistic clock rates.
    function automatic longint unsigned calc_tick_inc(
        input longint unsigned clk_freq,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned acc_width
    );
        return (((baud * os) << (acc_width - 64'd4)) + (clk_freq >> 5)) / (clk_freq >> 4);
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// ----------------------------------------------------------------------------
// uart_os_tick
//   Fractional-accumulator tick generator. Adds a constant increment every
//   clock; the carry out of the accumulator is the oversample tick, a
//   single-cycle pulse arriving on average BAUD*OVERSAMPLE times per second.
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     tick   out  one-cycle oversample tick
// ----------------------------------------------------------------------------
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [ACC_WIDTH:0] TICK_INC = (ACC_WIDTH + 1)'(calc_tick_inc(
        64'(CLK_FREQ), 64'(BAUD), 64'(OVERSAMPLE), 64'(ACC_WIDTH)));

    // The receiver's sample/bit counters assume exactly 16 ticks per bit.
    if (OVERSAMPLE != 16) begin : g_os_check
        $error("uart_os_tick: OVERSAMPLE must be 16");
    end

    // Bit ACC_WIDTH holds the carry of the previous add; it is dropped before
    // the next add, so the accumulator wraps freely and only the carry is used.
    logic [ACC_WIDTH:0] acc;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[ACC_WIDTH-1:0]} + TICK_INC;
        end
    end

    assign tick = acc[ACC_WIDTH];

endmodule

// File: rtl/uart_rx_os.sv
// ----------------------------------------------------------------------------
// uart_rx_os
//   8N1 UART receiver with its own 16x oversample tick, a 2-flop input
//   synchroniser, 3-sample majority voting at mid-bit and a valid/ready
//   output handshake.
//
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     rxd        in   serial line (asynchronous, idle high)
//     rx_data    out  received byte (first bit on the line is bit 0)
//     rx_valid   out  rx_data holds an unconsumed byte
//     rx_ready   in   consumer takes the byte when rx_valid && rx_ready
//     frame_err  out  one-cycle pulse: stop bit sampled low
//     overrun    out  one-cycle pulse: byte completed while rx_valid was set
//     busy       out  receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [3:0] S_MID  = 4'(OS_MID);
    localparam logic [3:0] S_LAST = 4'(OS_MID + 2);
    localparam logic [3:0] S_END  = 4'd15;

    logic       tick;
    logic [1:0] sync;
    logic       rxs;

    rx_state_t  state, state_n;
    logic [3:0] scnt, scnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [2:0] smp, smp_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, frame_err_n, overrun_n;
    logic       deliver, accept;

    uart_os_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Synchroniser resets to the idle-high line level so reset release never
    // looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rxs = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            smp       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            scnt      <= scnt_n;
            bcnt      <= bcnt_n;
            smp       <= smp_n;
            shreg     <= shreg_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n     = state;
        scnt_n      = scnt;
        bcnt_n      = bcnt;
        smp_n       = smp;
        shreg_n     = shreg;
        deliver     = 1'b0;
        frame_err_n = 1'b0;

        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_n = START;
                        scnt_n  = '0;
                    end
                end
                START: begin
                    scnt_n = scnt + 4'd1;
                    // A line that is high again at mid start bit was a glitch.
                    if (scnt == S_MID && rxs) begin
                        state_n = IDLE;
                    end else if (scnt == S_END) begin
                        state_n = DATA;
                        scnt_n  = '0;
                        bcnt_n  = '0;
                    end
                end
                DATA: begin
                    scnt_n = scnt + 4'd1;
                    if (scnt >= S_MID && scnt <= S_LAST) begin
                        smp_n = {smp[1:0], rxs};
                    end
                    if (scnt == S_END) begin
                        shreg_n = {maj3(smp), shreg[7:1]};
                        bcnt_n  = bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
                            state_n = STOP;
                            scnt_n  = '0;
                        end
                    end
                end
                STOP: begin
                    scnt_n = scnt + 4'd1;
                    if (scnt >= S_MID && scnt < S_LAST) begin
                        smp_n = {smp[1:0], rxs};
                    end
                    // Decide at the third sample (current rxs) rather than at
                    // bit end, leaving half a bit to resync on the next start.
                    if (scnt == S_LAST) begin
                        if (maj3({smp[1:0], rxs})) begin
                            deliver = 1'b1;
                            state_n = IDLE;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    if (rxs) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output handshake. A byte accepted in the same cycle a new one arrives
    // frees the holding register, so the new byte loads without overrun.
    always_comb begin
        accept     = rx_valid && rx_ready;
        rx_data_n  = rx_data;
        rx_valid_n = rx_valid;
        overrun_n  = 1'b0;
        if (deliver) begin
            if (!rx_valid || accept) begin
                rx_data_n  = shreg;
                rx_valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end else if (accept) begin
            rx_valid_n = 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_os
//   Self-checking bench for uart_rx_os. Frames are built bit by bit from the
//   8N1 rules; a monitor collects every byte handed over on rx_valid &&
//   rx_ready plus frame_err/overrun pulses, and the stimulus thread compares
//   them against the bytes it intended to send.
// ----------------------------------------------------------------------------
module tb_uart_rx_os;

    localparam int BIT_CLK = 217;   // 25 MHz / 115200 baud, rounded

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_os #(
        .CLK_FREQ  (25000000),
        .BAUD      (115200),
        .OVERSAMPLE(16),
        .ACC_WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #20 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         rd_idx = 0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    logic       valid_d = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_d <= 1'b0;
        end else begin
            if (rx_valid && !valid_d) begin
                rise_cnt <= rise_cnt + 1;
                rise_cyc <= cyc;
            end
            valid_d <= rx_valid;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (overrun) ov_cnt <= ov_cnt + 1;
            if (frame_err && overrun) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold rxd at val for n clocks; inputs change 1 ns after a rising edge.
    task automatic drive(input logic val, input int n);
        rxd = val;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame; gbit >= 0 puts a 1-clk inverted glitch near sample 8 of that bit.
    task automatic send_frame(input logic [7:0] d, input int per, input logic stop_bit, input int gbit);
        start_cyc = cyc;
        drive(1'b0, per);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                drive(d[i], 115);
                drive(~d[i], 1);
                drive(d[i], per - 116);
            end else begin
                drive(d[i], per);
            end
        end
        drive(stop_bit, per);
    endtask

    // Compare the next byte taken from the handshake against exp.
    task automatic next_byte(input string tag, input logic [7:0] exp);
        check({tag, "_avail"}, 32'(got_q.size() > rd_idx), 32'd1);
        if (got_q.size() > rd_idx) begin
            check(tag, 32'(got_q[rd_idx]), 32'(exp));
            rd_idx++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #(40 * 99000);
        $display("FAIL watchdog: simulation did not finish within 99000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, f0, o0, per;
        logic [7:0] d;

        // Reset state
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 50);

        // Basic byte with the consumer always ready
        rx_ready = 1'b1;
        r0 = rise_cnt;
        f0 = fe_cnt;
        send_frame(8'hA5, BIT_CLK, 1'b1, -1);
        drive(1'b1, 20);
        check("a5_valid_rises", 32'(rise_cnt - r0), 32'd1);
        check("a5_latency_ok", 32'(rise_cyc - start_cyc <= 10 * BIT_CLK + 20), 32'd1);
        next_byte("a5_data", 8'hA5);
        check("a5_single_pulse", 32'(got_q.size()), 32'(rd_idx));
        check("a5_no_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("a5_valid_low", 32'(rx_valid), 32'd0);

        // Back-to-back bytes with the consumer stalled: second byte overruns
        rx_ready = 1'b0;
        o0 = ov_cnt;
        send_frame(8'h55, BIT_CLK, 1'b1, -1);
        send_frame(8'h3C, BIT_CLK, 1'b1, -1);
        drive(1'b1, 40);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h55);
        check("ovr_pulse_count", 32'(ov_cnt - o0), 32'd1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(posedge clk);
        #1;
        check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
        next_byte("ovr_accepted", 8'h55);
        check("ovr_second_dropped", 32'(got_q.size()), 32'(rd_idx));
        rx_ready = 1'b1;

        // Short low pulse: false start rejected
        r0 = rise_cnt;
        drive(1'b0, 40);
        check("glitch_busy_seen", 32'(busy), 32'd1);
        drive(1'b1, 112);
        check("glitch_busy_dropped", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);

        // Stop bit low followed by a long break
        r0 = rise_cnt;
        f0 = fe_cnt;
        o0 = ov_cnt;
        send_frame(8'h81, BIT_CLK, 1'b0, -1);
        drive(1'b0, 50000);
        check("ferr_pulse_count", 32'(fe_cnt - f0), 32'd1);
        check("ferr_no_valid", 32'(rise_cnt - r0), 32'd0);
        check("ferr_no_overrun", 32'(ov_cnt - o0), 32'd0);
        check("ferr_busy_in_break", 32'(busy), 32'd1);
        drive(1'b1, BIT_CLK);
        check("ferr_busy_released", 32'(busy), 32'd0);
        send_frame(8'h81, BIT_CLK, 1'b1, -1);
        drive(1'b1, 20);
        next_byte("ferr_recovery", 8'h81);
        check("ferr_no_new_err", 32'(fe_cnt - f0), 32'd1);

        // Baud skew +/-3% and a single-clock glitch at mid-bit
        send_frame(8'hF0, 224, 1'b1, -1);
        drive(1'b1, 50);
        next_byte("skew_slow", 8'hF0);
        send_frame(8'hF0, 210, 1'b1, -1);
        drive(1'b1, 50);
        next_byte("skew_fast", 8'hF0);
        send_frame(8'hF0, BIT_CLK, 1'b1, 3);
        drive(1'b1, 50);
        next_byte("mid_glitch", 8'hF0);

        // Reset in the middle of bit 4 of 0x12, then a clean 0x34
        d = 8'h12;
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive(d[i], BIT_CLK);
        drive(d[4], 100);
        rst_n = 1'b0;
        drive(1'b1, 5);
        check_outputs_zero("mid_reset");
        rst_n = 1'b1;
        drive(1'b1, 100);
        check("mid_reset_nothing", 32'(got_q.size()), 32'(rd_idx));
        send_frame(8'h34, BIT_CLK, 1'b1, -1);
        drive(1'b1, 20);
        check("mid_reset_one_byte", 32'(got_q.size() - rd_idx), 32'd1);
        next_byte("mid_reset_data", 8'h34);

        // Random bytes at random small skews
        f0 = fe_cnt;
        o0 = ov_cnt;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            per = 212 + int'($urandom_range(0, 10));
            exp_q.push_back(d);
            send_frame(d, per, 1'b1, -1);
            drive(1'b1, 20 + int'($urandom_range(0, 100)));
        end
        foreach (exp_q[k]) next_byte($sformatf("rand_%0d", k), exp_q[k]);
        check("rand_no_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("rand_no_overrun", 32'(ov_cnt - o0), 32'd0);
        check("ferr_ovr_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
